// File: rtl/truth_table_pkg.sv
// Shared state encodings and golden truth tables for the truth-table sequencer.
package truth_table_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StDrive  = 2'd1,
        StSample = 2'd2,
        StDone   = 2'd3
    } state_e;

    // Golden tables for 2-input gates: bit i is the expected output for vec = i.
    localparam logic [3:0] ExpectedOr2  = 4'b1110;
    localparam logic [3:0] ExpectedAnd2 = 4'b1000;
    localparam logic [3:0] ExpectedXor2 = 4'b0110;

endpackage

// File: rtl/settle_timer.sv
// Settle countdown: load starts a window of SETTLE_CYCLES cycles; expired is high in its last cycle.
module settle_timer #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic expired
);

    localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CntW'(SETTLE_CYCLES - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/truth_table_sequencer.sv
// Sweeps every input vector of a combinational DUT, captures its output into a truth table.
// Optional golden-table compare is built only with TRUTH_TABLE_COMPARE_EN defined.
module truth_table_sequencer
    import truth_table_pkg::*;
#(
    parameter int unsigned        N_IN          = 2,
    parameter int unsigned        SETTLE_CYCLES = 1,
    parameter logic [2**N_IN-1:0] EXPECTED      = ExpectedOr2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    output logic [N_IN-1:0]      vec,
    input  logic                 c,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   result,
    output logic                 mismatch
);

    localparam int unsigned   Entries = 2**N_IN;
    localparam logic [N_IN:0] LastIdx = (N_IN + 1)'(Entries - 1);

    if (N_IN < 1 || N_IN > 4) begin : g_bad_n_in
        $error("truth_table_sequencer: N_IN must be in 1..4");
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
        $error("truth_table_sequencer: SETTLE_CYCLES must be >= 1");
    end

    state_e              state_q, state_d;
    logic [N_IN:0]       idx_q, idx_d;
    logic [Entries-1:0]  result_q, result_d;
    logic                load;
    logic                expired;
    logic                last_sample;

    settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_settle_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (load),
        .expired (expired)
    );

    assign last_sample = (idx_q == LastIdx);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        result_d = result_q;
        load     = 1'b0;
        unique case (state_q)
            StIdle: begin
                // start beats abort here; abort alone is a no-op
                if (start) begin
                    state_d  = StDrive;
                    idx_d    = '0;
                    result_d = '0;
                    load     = 1'b1;
                end
            end
            StDrive: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (expired) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                // abort suppresses both the capture and the final transition
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    result_d[idx_q[N_IN-1:0]] = c;
                    if (last_sample) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + (N_IN + 1)'(1);
                        state_d = StDrive;
                        load    = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            result_q <= result_d;
        end
    end

    assign vec    = idx_q[N_IN-1:0];
    assign result = result_q;
    assign busy   = (state_q == StDrive) || (state_q == StSample);
    assign done   = (state_q == StDone);

`ifdef TRUTH_TABLE_COMPARE_EN
    logic mismatch_q, mismatch_d;

    // Registered on the SAMPLE->DONE edge so it is valid alongside done
    always_comb begin
        mismatch_d = mismatch_q;
        if (state_q == StIdle && start) begin
            mismatch_d = 1'b0;
        end else if (state_q == StSample && !abort && last_sample) begin
            mismatch_d = (result_d != EXPECTED);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch = mismatch_q;
`else
    assign mismatch = 1'b0;
`endif

endmodule

// File: doc/truth_table_sequencer.md
TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

Interface
REQ-001 The block SHALL have parameter N_IN, default 2, meaning the DUT input count (legal 1..4).
REQ-002 The block SHALL have parameter SETTLE_CYCLES, default 1, meaning the cycles each vector is held before sampling (legal >= 1).
REQ-003 The block SHALL have parameter EXPECTED, default 4'b1110, meaning the golden truth table (width 2**N_IN, bit i = expected c for vector i).
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 The block SHALL have port clk, input, 1, meaning the system clock (rising edge).
REQ-006 The block SHALL have port reset, input, 1, meaning the asynchronous active-high reset.
REQ-007 The block SHALL have port start, input, 1, meaning a sweep request.
REQ-008 The block SHALL have port abort, input, 1, meaning cancel the sweep in progress.
REQ-009 The block SHALL have port vec, output, N_IN, meaning the DUT input drive (vec[0]=a, vec[1]=b, ...).
REQ-010 The block SHALL have port c, input, 1, meaning the DUT combinational output.
REQ-011 The block SHALL have port busy, output, 1, meaning a sweep is in progress.
REQ-012 The block SHALL have port done, output, 1, meaning a one-cycle sweep-complete pulse.
REQ-013 The block SHALL have port result, output, 2**N_IN, meaning the captured truth table (bit i = c sampled for vec=i).
REQ-014 The block SHALL have port mismatch, output, 1, meaning result differs from EXPECTED.

Function
REQ-015 The FSM SHALL have four states: IDLE, DRIVE, SAMPLE and DONE.
REQ-016 In IDLE, a sampled start SHALL move the FSM to DRIVE, clear result to 0, set vec and the index to 0, and clear mismatch.
REQ-017 DRIVE SHALL hold vec for exactly SETTLE_CYCLES cycles and then go to SAMPLE.
REQ-018 SAMPLE SHALL last one cycle and write result[idx] <= c.
REQ-019 If idx == 2**N_IN-1, SAMPLE SHALL go to DONE; otherwise it SHALL increment idx and vec and go to DRIVE.
REQ-020 DONE SHALL assert done for exactly one cycle and then return unconditionally to IDLE.
REQ-021 busy SHALL be 1 in DRIVE and SAMPLE, and 0 in IDLE and DONE.
REQ-022 With start accepted at edge 0, done SHALL be high in cycle 2**N_IN*(SETTLE_CYCLES+1)+1 (cycle 9 for the defaults).
REQ-023 start SHALL be ignored in DRIVE, SAMPLE and DONE, with no queuing.
REQ-024 abort in DRIVE or SAMPLE SHALL move the FSM to IDLE on the next edge, with no done pulse, keeping the partial result and vec at their last values.
REQ-025 abort SHALL win over a SAMPLE-to-DONE transition in the same cycle, so no done pulse occurs.
REQ-026 abort SHALL have no effect in IDLE or DONE.
REQ-027 If start and abort are both high in IDLE, start SHALL take effect.
REQ-028 vec, result and mismatch SHALL hold their values in IDLE until the next accepted start.
REQ-029 The index counter SHALL be N_IN+1 bits wide, and vec SHALL be its low N_IN bits.
REQ-030 The index SHALL NOT wrap within a sweep.

Reset
REQ-031 reset SHALL asynchronously force the state to IDLE, vec=0, idx=0, result=0, busy=0, done=0, mismatch=0 and the settle counter to 0.
REQ-032 A reset asserted mid-sweep SHALL discard the sweep with no done pulse.
REQ-033 After reset is released, the block SHALL wait for a new start.

Configuration
REQ-034 With macro TRUTH_TABLE_COMPARE_EN defined, mismatch SHALL be registered on entry to DONE as (result_next != EXPECTED), be valid in the same cycle as done, and hold until the next start or reset.
REQ-035 Without TRUTH_TABLE_COMPARE_EN, the mismatch port SHALL remain present, be tied to 0, and no comparator logic SHALL be built.

Structure
REQ-036 The shared package truth_table_pkg SHALL hold the state encodings (IDLE=2'd0, DRIVE=2'd1, SAMPLE=2'd2, DONE=2'd3) and the default EXPECTED constants for OR, AND and XOR.
REQ-037 The settle countdown SHALL be implemented as the sub-module settle_timer (inputs load and clk/reset, output expired), loaded with SETTLE_CYCLES on each entry to DRIVE.
REQ-038 The FSM, index and result registers SHALL reside in truth_table_sequencer.

Verification
REQ-039 Defaults, DUT = 2-input OR, start pulse -> vec steps 0,1,2,3; result=4'b1110; done in cycle 9; mismatch=0 (with the macro).
REQ-040 DUT = AND, EXPECTED=4'b1110, macro defined -> result=4'b1000; mismatch=1 coincident with done and held afterwards.
REQ-041 SETTLE_CYCLES=3, N_IN=3, OR3 DUT -> done in cycle 33; result=8'b1111_1110.
REQ-042 abort asserted during the SAMPLE of vector 2 -> FSM returns to IDLE; no done pulse; result=4'b0010 (OR, bits 0 to 1 sampled, bit 2 not written); busy=0.
REQ-043 reset pulsed asynchronously mid-DRIVE -> all outputs are 0 immediately; a following start runs a full clean sweep.
REQ-044 start held high continuously -> a sweep every 10 cycles (9 plus 1 IDLE); start pulses during busy are ignored; result is cleared at each new start.
